serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor, the counterpart of the combinational adder cells. It accepts two WIDTH-bit operands on a START pulse and computes A minus B LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. The result and final borrow are presented with a one-cycle DONE pulse. It serves as the lab datapath block for multi-cycle arithmetic using an FSM, a counter and shift registers.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A - B LSB-first, one bit per clock,
// through a single full-subtractor cell and a borrow flip-flop.
// The result and final borrow are presented with a one-cycle DONE pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic             w_accept;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign w_a       = r_sa[0];
  assign w_b       = r_sb[0];
  assign w_d       = w_a ^ w_b ^ r_br;
  assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

  // The counter stops at WIDTH-1 on the last RUN cycle, so it never wraps.
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && START;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode: IDLE waits for START, RUN lasts WIDTH cycles, FIN is one cycle.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (START) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand shift registers, result shift register, borrow FF and bit counter.
  // NOTE: datapath registers are reset too, so an aborted operation leaves no residue.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_sr  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sa  <= A;
      r_sb  <= B;
      r_sr  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sr  <= {w_d, r_sr[WIDTH-1:1]};
      r_br  <= w_br_next;
      r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
    end
  end

  // Result registers load at the RUN-to-FIN edge, including the final bit, and hold otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_diff   <= {w_d, r_sr[WIDTH-1:1]};
      r_borrow <= w_br_next;
    end
  end

  // Status flags are decoded from state only: no combinational path from inputs.
  assign BUSY   = (r_state == RUN);
  assign DONE   = (r_state == FIN);
  assign DIFF   = r_diff;
  assign BORROW = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DIFF;
  logic             BORROW;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .DIFF   (DIFF),
    .BORROW (BORROW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check outputs against expected values.
  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b0;
    A     = '0;
    B     = '0;
    #3;
    checks++;
    if ({BUSY, DONE, DIFF, BORROW} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h borrow=%b, expected 0 0 00 0",
               BUSY, DONE, DIFF, BORROW);
    end
    step();
    step();
    RST_N = 1'b1;
    step();
    checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", BUSY, DONE);
    end
  endtask

  // One full operation from IDLE: checks latency, busy length, result and DONE width.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_diff, input logic exp_borrow,
                        input string name);
    int cyc;
    int busy_cnt;
    logic [7:0] prev_diff;
    logic diff_moved;
    prev_diff  = DIFF;
    diff_moved = 1'b0;
    A     = a;
    B     = b;
    START = 1'b1;
    step();            // accept edge 0; now in cycle 1
    START = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (!DONE && cyc < 40) begin
      if (BUSY) busy_cnt++;
      if (DIFF !== prev_diff) diff_moved = 1'b1;
      step();
      cyc++;
    end
    checks++;
    if (cyc !== WIDTH + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d, expected %0d", name, cyc, WIDTH + 1);
    end
    checks++;
    if (busy_cnt !== WIDTH) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, WIDTH);
    end
    checks++;
    if (diff_moved !== 1'b0) begin
      errors++;
      $display("FAIL %s diff_stable_in_run: got changed, expected held at %h", name, prev_diff);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_fin: got %b, expected 0", name, BUSY);
    end
    checks++;
    if ({DIFF, BORROW} !== {exp_diff, exp_borrow}) begin
      errors++;
      $display("FAIL %s result: got diff=%h borrow=%b, expected diff=%h borrow=%b",
               name, DIFF, BORROW, exp_diff, exp_borrow);
    end
    step();
    checks++;
    if ({DONE, BUSY, DIFF} !== {1'b0, 1'b0, exp_diff}) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b diff=%h, expected 0 0 %h",
               name, DONE, BUSY, DIFF, exp_diff);
    end
  endtask

  task automatic test_basic();
    run_op(8'h5A, 8'h23, 8'h37, 1'b0, "sub_5a_23");
    run_op(8'h23, 8'h5A, 8'hC9, 1'b1, "sub_23_5a");
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, "ripple_00_01");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal_ff_ff");
    run_op(8'h80, 8'h00, 8'h80, 1'b0, "msb_80_00");
  endtask

  // Result holds in IDLE while inputs wander.
  task automatic test_hold();
    A = 8'h12;
    B = 8'h34;
    repeat (6) step();
    checks++;
    if ({DIFF, BORROW} !== {8'h80, 1'b0}) begin
      errors++;
      $display("FAIL hold: got diff=%h borrow=%b, expected diff=80 borrow=0", DIFF, BORROW);
    end
  endtask

  // START during RUN is ignored and operand changes after acceptance have no effect.
  task automatic test_start_in_run();
    int done_cnt;
    A     = 8'h10;
    B     = 8'h01;
    START = 1'b1;
    step();            // accepted; cycle 1
    START = 1'b0;
    step();            // cycle 2
    step();            // cycle 3
    START = 1'b1;
    A     = 8'h00;
    B     = 8'hFF;
    step();            // cycle 4
    START = 1'b0;
    A     = 8'hAA;
    B     = 8'h55;
    done_cnt = 0;
    for (int c = 4; c < 30; c++) begin
      if (DONE) begin
        done_cnt++;
        checks++;
        if ({DIFF, BORROW} !== {8'h0F, 1'b0}) begin
          errors++;
          $display("FAIL start_in_run result: got diff=%h borrow=%b, expected diff=0f borrow=0",
                   DIFF, BORROW);
        end
      end
      step();
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL start_in_run done_count: got %0d, expected 1", done_cnt);
    end
  endtask

  // Asynchronous reset in RUN cycle 4 clears everything immediately.
  task automatic test_async_reset();
    A     = 8'h5A;
    B     = 8'h23;
    START = 1'b1;
    step();            // cycle 1
    START = 1'b0;
    step();            // cycle 2
    step();            // cycle 3
    step();            // cycle 4 (posedge + 1)
    #2;                // mid-cycle, away from both clock edges
    RST_N = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, DIFF, BORROW} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h borrow=%b, expected 0 0 00 0",
               BUSY, DONE, DIFF, BORROW);
    end
    step();
    #2;
    RST_N = 1'b1;
    step();
    run_op(8'h05, 8'h03, 8'h02, 1'b0, "after_reset_05_03");
  endtask

  // START held high: one result every WIDTH+2 cycles, BUSY never overlaps DONE.
  task automatic test_back_to_back();
    int done_cnt;
    int next_done;
    A         = 8'h33;
    B         = 8'h11;
    START     = 1'b1;
    step();            // accept edge 0; cycle 1
    done_cnt  = 0;
    next_done = WIDTH + 1;
    for (int c = 1; c <= 30; c++) begin
      if (DONE) begin
        done_cnt++;
        checks++;
        if (c !== next_done) begin
          errors++;
          $display("FAIL b2b done_cycle: got %0d, expected %0d", c, next_done);
        end
        checks++;
        if ({DIFF, BORROW, BUSY} !== {8'h22, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL b2b result: got diff=%h borrow=%b busy=%b, expected diff=22 borrow=0 busy=0",
                   DIFF, BORROW, BUSY);
        end
        next_done = c + WIDTH + 2;
      end
      step();
    end
    START = 1'b0;
    checks++;
    if (done_cnt !== 3) begin
      errors++;
      $display("FAIL b2b done_count: got %0d, expected 3", done_cnt);
    end
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_in_run();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
